// File: rtl/lcd_write_sequencer.sv
// rtl/lcd_write_sequencer.sv - HD44780 write sequencer: power-up init ROM, then single-byte writes over valid/ready.
module lcd_write_sequencer #(
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_PULSE   = 25,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned T_EXEC    = 2000,
  parameter int unsigned T_LONG    = 210000,
  parameter int unsigned T_POWERUP = 2000000,
  parameter bit          INIT_EN   = 1'b1,
  parameter int unsigned CW        = 22
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        req_valid,
  input  logic        req_rs,
  input  logic [7:0]  req_data,
  output logic        req_ready,
  output logic        init_done,
  output logic        busy,
  output logic [10:0] lcdPins
);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC,
    S_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          long_q, long_d;
  logic          init_done_q, init_done_d;
  logic          e_q;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h30;
      3'd3:             init_rom = 8'h38;
      3'd4:             init_rom = 8'h08;
      3'd5:             init_rom = 8'h01;
      3'd6:             init_rom = 8'h06;
      default:          init_rom = 8'h0C;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    long_d      = long_q;
    init_done_d = init_done_q;
    case (state_q)
      // Reset leaves the counter at zero, so power-up counts upward to its limit.
      S_POWERUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(T_POWERUP - 1)) begin
          cnt_d = '0;
          if (INIT_EN) begin
            state_d = S_INIT_LOAD;
            idx_d   = 3'd0;
            rs_d    = 1'b0;
            data_d  = init_rom(3'd0);
            long_d  = 1'b1;
          end else begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end
        end
      end
      S_INIT_LOAD: begin
        state_d = S_SETUP;
        cnt_d   = CW'(T_SETUP - 1);
      end
      S_SETUP: if (cnt_q == '0) begin
        state_d = S_PULSE;
        cnt_d   = CW'(T_PULSE - 1);
      end
      S_PULSE: if (cnt_q == '0) begin
        state_d = S_HOLD;
        cnt_d   = CW'(T_HOLD - 1);
      end
      S_HOLD: if (cnt_q == '0) begin
        state_d = S_EXEC;
        cnt_d   = long_q ? CW'(T_LONG - 1) : CW'(T_EXEC - 1);
      end
      S_EXEC: if (cnt_q == '0) begin
        if (init_done_q) begin
          state_d = S_IDLE;
        end else if (idx_q == 3'd7) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d = S_INIT_LOAD;
          idx_d   = idx_q + 3'd1;
          rs_d    = 1'b0;
          data_d  = init_rom(idx_q + 3'd1);
          long_d  = (idx_q + 3'd1 == 3'd5);
        end
      end
      S_IDLE: if (req_valid) begin
        state_d = S_SETUP;
        cnt_d   = CW'(T_SETUP - 1);
        rs_d    = req_rs;
        data_d  = req_data;
        // Clear display and return home need the long execution wait.
        long_d  = !req_rs && (req_data[7:2] == 6'd0) && (req_data != 8'd0);
      end
      default: state_d = S_POWERUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q     <= S_POWERUP;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      long_q      <= 1'b0;
      init_done_q <= 1'b0;
      e_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      long_q      <= long_d;
      init_done_q <= init_done_d;
      e_q         <= (state_d == S_PULSE);
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign init_done = init_done_q;
  assign lcdPins   = {rs_q, 1'b0, e_q, data_q};

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb/tb_lcd_write_sequencer.sv - directed vector bench for lcd_write_sequencer.
module tb_lcd_write_sequencer;

  localparam int TS = 2, TP = 2, TH = 2, TE = 5, TL = 20, TPU = 10;

  logic        clk = 1'b0;
  logic        rst_in, rst1;
  logic        req_valid, req_rs;
  logic [7:0]  req_data;
  logic        req_ready, init_done, busy;
  logic [10:0] pins;
  logic        ready1, init_done1, busy1;
  logic [10:0] pins1;

  int n_cmp = 0;
  int n_fail = 0;
  int rw_bad = 0;

  logic [7:0] rom_exp [0:7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rdy_lat;
  } vec_t;

  vec_t vecs [0:7];

  always #5 clk = ~clk;

  lcd_write_sequencer #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_LONG(TL),
    .T_POWERUP(TPU), .INIT_EN(1'b1), .CW(22)
  ) u_dut (
    .clk(clk), .rst_in(rst_in), .req_valid(req_valid), .req_rs(req_rs),
    .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
    .busy(busy), .lcdPins(pins)
  );

  lcd_write_sequencer #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_LONG(TL),
    .T_POWERUP(TPU), .INIT_EN(1'b0), .CW(22)
  ) u_noinit (
    .clk(clk), .rst_in(rst1), .req_valid(1'b0), .req_rs(1'b0),
    .req_data(8'h00), .req_ready(ready1), .init_done(init_done1),
    .busy(busy1), .lcdPins(pins1)
  );

  always @(negedge clk) begin
    if (pins[9] || pins1[9]) rw_bad++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic capture_init(input bit chk_u1);
    int   rises[$];
    logic [7:0] ds[$];
    int   n_done = -1;
    int   n1_done = -1;
    bit   e_prev = 1'b0;
    bit   e1_seen = 1'b0;
    int   exp_rise;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (pins[8] && !e_prev) begin
        rises.push_back(n);
        ds.push_back(pins[7:0]);
      end
      e_prev = pins[8];
      if (n_done < 0 && init_done) n_done = n;
      if (chk_u1) begin
        if (pins1[8]) e1_seen = 1'b1;
        if (n1_done < 0 && init_done1 && ready1) n1_done = n;
      end
      if (n_done >= 0 && (!chk_u1 || n1_done >= 0)) break;
    end
    check("init_pulse_count", rises.size(), 8);
    exp_rise = TPU + 1 + TS;
    for (int i = 0; i < 8 && i < rises.size(); i++) begin
      check($sformatf("init_data[%0d]", i), ds[i], rom_exp[i]);
      check($sformatf("init_rise[%0d]", i), rises[i], exp_rise);
      exp_rise = exp_rise + TP + TH + ((i == 0 || i == 5) ? TL : TE) + 1 + TS;
    end
    check("init_done_time", n_done, exp_rise - (1 + TS));
    check("ready_after_init", req_ready, 1);
    if (chk_u1) begin
      check("noinit_e_pulse", e1_seen, 0);
      check("noinit_done_time", n1_done, TPU);
    end
  endtask

  initial begin
    int erise, elen, rdy;
    int b2b_rises[$];
    int ready_hi;
    int phase;
    bit eprev;
    bit e_seen;

    vecs[0] = '{1'b1, 8'h41, TS + TP + TH + TE};
    vecs[1] = '{1'b0, 8'h01, TS + TP + TH + TL};
    vecs[2] = '{1'b0, 8'h80, TS + TP + TH + TE};
    vecs[3] = '{1'b0, 8'h02, TS + TP + TH + TL};
    vecs[4] = '{1'b0, 8'h03, TS + TP + TH + TL};
    vecs[5] = '{1'b0, 8'h04, TS + TP + TH + TE};
    vecs[6] = '{1'b1, 8'h01, TS + TP + TH + TE};
    vecs[7] = '{1'b0, 8'h00, TS + TP + TH + TE};

    rst_in = 1'b0; rst1 = 1'b0;
    req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_pins", pins, 0);
    check("reset_ready", req_ready, 0);
    check("reset_busy", busy, 1);
    check("reset_init_done", init_done, 0);
    check("reset_noinit_ready", ready1, 0);
    rst_in = 1'b1; rst1 = 1'b1;
    capture_init(1'b1);

    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d_ready_pre", i), req_ready, 1);
      req_valid = 1'b1; req_rs = vecs[i].rs; req_data = vecs[i].data;
      @(negedge clk);
      req_valid = 1'b0;
      check($sformatf("v%0d_rs", i), pins[10], vecs[i].rs);
      check($sformatf("v%0d_data", i), pins[7:0], vecs[i].data);
      check($sformatf("v%0d_ready_drop", i), req_ready, 0);
      erise = -1; elen = 0; rdy = -1;
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (pins[8]) begin
          if (erise < 0) erise = k;
          elen++;
        end
        if (req_ready) begin
          rdy = k;
          break;
        end
      end
      check($sformatf("v%0d_e_rise", i), erise, TS);
      check($sformatf("v%0d_e_len", i), elen, TP);
      check($sformatf("v%0d_ready_lat", i), rdy, vecs[i].rdy_lat);
    end

    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h48;
    ready_hi = 0; phase = 0; eprev = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (pins[8] && !eprev) b2b_rises.push_back(k);
      eprev = pins[8];
      if (phase == 0 && !req_ready) begin
        phase = 1;
        req_data = 8'h49;
      end else if ((phase == 1 || phase == 2) && req_ready) begin
        ready_hi++;
        phase = 2;
      end else if (phase == 2 && !req_ready) begin
        phase = 3;
        req_valid = 1'b0;
      end else if (phase == 3 && req_ready) begin
        break;
      end
    end
    check("b2b_pulses", b2b_rises.size(), 2);
    if (b2b_rises.size() == 2)
      check("b2b_rise_gap", b2b_rises[1] - b2b_rises[0], TS + TP + TH + TE + 1);
    check("b2b_ready_window", ready_hi, 1);
    check("b2b_final_data", pins[7:0], 8'h49);
    req_valid = 1'b0;

    @(negedge clk);
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    e_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pins[8]) begin
        e_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midwrite_e_high", e_seen, 1);
    rst_in = 1'b0;
    @(negedge clk);
    check("midwrite_reset_pins", pins, 0);
    check("midwrite_reset_init_done", init_done, 0);
    check("midwrite_reset_busy", busy, 1);
    rst_in = 1'b1;
    capture_init(1'b0);

    check("rw_always_zero", rw_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
